// File: rtl/req_chan_mngr_q.sv
// rtl/req_chan_mngr_q.sv - queued request channel manager with arbitration and credit-limited issue
module req_chan_mngr_q #(
  parameter int               MID_W     = 2,
  parameter logic [MID_W-1:0] REQC_M_ID = '0,
  parameter int               CNT_W     = 2,
  parameter int               ADDR_W    = 32,
  parameter int               DEPTH     = 4,
  parameter int               MAX_OUTST = 4,
  parameter int               OC_W      = $clog2(MAX_OUTST + 1),
  parameter int               QC_W      = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   req_rq,
  input  logic                   gnt_rq,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [MID_W+CNT_W-1:0] a_id,
  output logic [ADDR_W-1:0]      a_addr,
  output logic [5:0]             a_atop,
  input  logic                   start_rq,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [5:0]             in_atop,
  output logic                   in_ready,
  input  logic                   rsp_done,
  output logic                   next_rq,
  output logic [MID_W+CNT_W-1:0] next_id,
  output logic [OC_W-1:0]        outst,
  output logic [QC_W-1:0]        q_cnt
);

  localparam int              PW     = $clog2(DEPTH);
  localparam logic [OC_W-1:0] MAX_O  = OC_W'(MAX_OUTST);
  localparam logic [QC_W-1:0] FULL_Q = QC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    AREQ = 2'b01,
    BOUT = 2'b10
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [5:0]        mem_atop [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  id_cntr;
  logic              push;
  logic              pop;
  logic              dec;
  logic [QC_W-1:0]   q_cnt_next;
  logic [OC_W-1:0]   outst_next;
  logic              can_go;
  logic              go_next;

  // Channel outputs decode straight from the state register; the handshake strobe adds a_ready.
  assign req_rq     = (state == AREQ);
  assign a_valid    = (state == BOUT);
  assign next_rq    = a_valid & a_ready;
  assign in_ready   = (q_cnt != FULL_Q);
  assign push       = start_rq & in_ready;
  assign pop        = next_rq;
  // A retirement with nothing outstanding is a stray pulse and must not underflow.
  assign dec        = rsp_done & (outst != '0);
  assign q_cnt_next = q_cnt + QC_W'(push) - QC_W'(pop);
  assign outst_next = outst + OC_W'(next_rq) - OC_W'(dec);
  assign can_go     = (q_cnt != '0) & (outst < MAX_O);
  assign go_next    = (q_cnt_next != '0) & (outst_next < MAX_O);
  assign a_id       = {REQC_M_ID, id_cntr};
  assign a_addr     = mem_addr[rd_ptr];
  assign a_atop     = mem_atop[rd_ptr];

  // FIFO storage: write at the tail on an accepted push; contents reset to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr[i] <= '0;
        mem_atop[i] <= '0;
      end
    end else if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_atop[wr_ptr] <= in_atop;
    end
  end

  // Pointers, occupancy, credit and ID bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_cnt   <= '0;
      outst   <= '0;
      id_cntr <= '0;
      next_id <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      q_cnt <= q_cnt_next;
      outst <= outst_next;
      if (next_rq) begin
        id_cntr <= id_cntr + CNT_W'(1);
        next_id <= a_id;
      end
    end
  end

  // Issue FSM: request the channel, present one beat per grant, chain directly when work and credit remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        AREQ:    if (gnt_rq) state <= BOUT;
        BOUT:    if (a_ready) state <= go_next ? AREQ : IDLE;
        default: state <= can_go ? AREQ : IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_chan_mngr_q.sv
// tb/tb_req_chan_mngr_q.sv - randomized and directed bench against a queue-based reference model
module tb_req_chan_mngr_q;

  localparam int         DEPTH = 4;
  localparam int         MAXO  = 2;
  localparam logic [1:0] M_ID  = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_rq, gnt_rq, a_valid, a_ready, start_rq, in_ready, rsp_done, next_rq;
  logic [3:0]  a_id, next_id;
  logic [31:0] a_addr, in_addr;
  logic [5:0]  a_atop, in_atop;
  logic [1:0]  outst;
  logic [2:0]  q_cnt;

  req_chan_mngr_q #(
    .MID_W(2), .REQC_M_ID(M_ID), .CNT_W(2), .ADDR_W(32), .DEPTH(DEPTH), .MAX_OUTST(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_rq(req_rq), .gnt_rq(gnt_rq), .a_valid(a_valid),
    .a_ready(a_ready), .a_id(a_id), .a_addr(a_addr), .a_atop(a_atop), .start_rq(start_rq),
    .in_addr(in_addr), .in_atop(in_atop), .in_ready(in_ready), .rsp_done(rsp_done),
    .next_rq(next_rq), .next_id(next_id), .outst(outst), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // reference model: queue of {atop,addr}, phase 0=waiting 1=requesting 2=presenting
  logic [37:0] m_q[$];
  int          m_phase = 0;
  int          m_outst = 0;
  int          m_id = 0;
  logic [3:0]  m_next_id = 4'b0000;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_phase = 0;
    m_outst = 0;
    m_id = 0;
    m_next_id = 4'b0000;
  endtask

  task automatic model_step();
    bit hs, pu, dc;
    int qs0, os0;
    qs0 = m_q.size();
    os0 = m_outst;
    hs = (m_phase == 2) && a_ready;
    pu = start_rq && (qs0 < DEPTH);
    dc = rsp_done && (os0 > 0);
    if (hs) begin
      m_next_id = {M_ID, m_id[1:0]};
      m_id = (m_id + 1) % 4;
      m_q.delete(0);
    end
    if (pu) m_q.push_back({in_atop, in_addr});
    m_outst = os0 + int'(hs) - int'(dc);
    case (m_phase)
      0: if (qs0 > 0 && os0 < MAXO) m_phase = 1;
      1: if (gnt_rq) m_phase = 2;
      default: if (a_ready) m_phase = (m_q.size() > 0 && m_outst < MAXO) ? 1 : 0;
    endcase
  endtask

  // every-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_rq", req_rq, m_phase == 1);
      chk("a_valid", a_valid, m_phase == 2);
      chk("next_rq", next_rq, (m_phase == 2) && a_ready);
      chk("in_ready", in_ready, m_q.size() < DEPTH);
      chk("q_cnt", q_cnt, m_q.size());
      chk("outst", outst, m_outst);
      chk("a_id", a_id, {M_ID, m_id[1:0]});
      chk("next_id", next_id, m_next_id);
      if (m_q.size() > 0) begin
        chk("a_addr", a_addr, m_q[0][31:0]);
        chk("a_atop", a_atop, m_q[0][37:32]);
      end
    end
  end

  task automatic cyc(input bit s, input logic [31:0] ad, input logic [5:0] at,
                     input bit g, input bit r, input bit d);
    start_rq = s; in_addr = ad; in_atop = at; gnt_rq = g; a_ready = r; rsp_done = d;
    @(negedge clk);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input bit g, input bit r, input bit d);
    cyc(1'b0, 32'h0, 6'h0, g, r, d);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req_rq && n < 10) begin
      idle(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("wait_req_timeout", req_rq, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  logic [31:0] la;

  initial begin
    start_rq = 0; in_addr = 0; in_atop = 0; gnt_rq = 0; a_ready = 0; rsp_done = 0;
    #1 rst_n = 1'b0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset values
    chk("rst_req", req_rq, 1'b0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_a_id", a_id, 4'b0100);
    chk("rst_next_id", next_id, 4'b0000);
    chk("rst_outst", outst, 2'd0);
    chk("rst_q_cnt", q_cnt, 3'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_atop", a_atop, 6'h0);

    // single request with the documented latency
    cyc(1'b1, 32'h1000_0040, 6'h0, 1'b0, 1'b1, 1'b0);
    chk("single_qcnt", q_cnt, 3'd1);
    chk("single_req_early", req_rq, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    chk("single_req", req_rq, 1'b1);
    idle(1'b1, 1'b1, 1'b0);
    chk("single_valid", a_valid, 1'b1);
    chk("single_addr", a_addr, 32'h1000_0040);
    chk("single_id", a_id, 4'b0100);
    idle(1'b0, 1'b1, 1'b0);
    chk("single_valid_drop", a_valid, 1'b0);
    chk("single_next_id", next_id, 4'b0100);
    chk("single_outst", outst, 2'd1);
    chk("single_qcnt0", q_cnt, 3'd0);
    idle(1'b0, 1'b0, 1'b1);
    chk("retire_outst", outst, 2'd0);
    idle(1'b0, 1'b0, 1'b1);
    chk("retire_underflow", outst, 2'd0);

    // fill and overflow; ID counter starts at 1 here and wraps 3 -> 0
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 32'(16 * (k + 1)), 6'(k), 1'b0, 1'b1, 1'b0);
      if (k == 3) chk("fill_in_ready", in_ready, 1'b0);
    end
    chk("fill_qcnt", q_cnt, 3'd4);
    for (int k = 0; k < 4; k++) begin
      wait_req();
      idle(1'b1, 1'b1, 1'b0);
      chk("order_addr", a_addr, 32'(16 * (k + 1)));
      la = 32'((k + 1) % 4);
      chk("order_id", a_id, {M_ID, la[1:0]});
      cyc(k == 2, 32'h60, 6'h3f, 1'b0, 1'b1, 1'b1);
      chk("hs_rsp_outst", outst, 2'd1);
      if (k == 2) chk("push_pop_qcnt", q_cnt, 3'd2);
    end
    for (int n = 0; n < 40 && (q_cnt != 0 || outst != 0 || req_rq || a_valid); n++)
      idle(1'b1, 1'b1, 1'b1);
    chk("drain", {q_cnt, outst, req_rq, a_valid}, 7'b0);

    // credit limit
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h200 + 32'(k), 6'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 1'b1, 1'b0);
      chk("credit_stall_req", req_rq, 1'b0);
    end
    chk("credit_outst", outst, 2'd2);
    chk("credit_qcnt", q_cnt, 3'd1);
    idle(1'b0, 1'b0, 1'b1);
    chk("credit_req_t1", req_rq, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    chk("credit_req_t2", req_rq, 1'b1);
    idle(1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b1, 1'b0);
    chk("credit_outst_back", outst, 2'd2);
    chk("credit_qcnt0", q_cnt, 3'd0);

    // backpressure with ignored grants
    idle(1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 32'hABCD_0000, 6'h15, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 1'b0, 1'b0);
      chk("bp_valid", a_valid, 1'b1);
      chk("bp_addr", a_addr, 32'hABCD_0000);
      chk("bp_atop", a_atop, 6'h15);
    end
    idle(1'b0, 1'b1, 1'b0);
    chk("bp_release_valid", a_valid, 1'b0);
    chk("bp_release_outst", outst, 2'd1);

    // reset mid-operation
    idle(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 32'h300 + 32'(k), 6'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 1'b0);
    chk("mid_valid_before", a_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", a_valid, 1'b0);
    chk("mid_rst_qcnt", q_cnt, 3'd0);
    chk("mid_rst_outst", outst, 2'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle(1'b1, 1'b1, 1'b0);
      chk("post_rst_req", req_rq, 1'b0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 10) < 4, $urandom, 6'($urandom), ($urandom % 2) == 1,
          ($urandom % 10) < 6, ($urandom % 10) < 3);
    end

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
